// File: rtl/led_bank_arbiter_if.sv
// Bus between the LED pattern sources and the LED bank arbiter.
// The master side drives the enable, requests and patterns; the slave side
// (the arbiter) returns the grant, the pin pattern, the tristate enable and busy.
interface led_bank_arbiter_if;
   logic       en;
   logic [2:0] req;
   logic [3:0] pat0;
   logic [3:0] pat1;
   logic [3:0] pat2;
   logic [2:0] gnt;
   logic [3:0] led_o;
   logic       led_oe;
   logic       busy;

   modport master (
      output en, req, pat0, pat1, pat2,
      input  gnt, led_o, led_oe, busy
   );

   modport slave (
      input  en, req, pat0, pat1, pat2,
      output gnt, led_o, led_oe, busy
   );
endinterface

// File: rtl/led_bank_arbiter.sv
// Shares the 4-pin dual-purpose LED bank between three pattern sources.
// The bank is released for a turnaround gap before it is driven from a
// released state; a grant lasts at least MIN_HOLD cycles and, when another
// source is waiting, at most MAX_HOLD cycles. Arbitration is round-robin.
// Handovers between sources happen without a gap because the pins are
// already being driven by this block.
module led_bank_arbiter #(
   parameter logic [31:0] MIN_HOLD   = 32'd48_000,
   parameter logic [31:0] MAX_HOLD   = 32'd48_000_000,
   parameter logic [7:0]  GAP_CYCLES = 8'd4
) (
   input logic               clk,
   input logic               rst_n,
   led_bank_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GAP   = 2'd1,
      GRANT = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [2:0]  gnt_q,   gnt_d;
   logic [3:0]  led_q,   led_d;
   logic        oe_q,    oe_d;
   logic [31:0] hold_q,  hold_d;
   logic [7:0]  gap_q,   gap_d;
   logic [1:0]  last_q,  last_d;
   logic [1:0]  win_q,   win_d;

   logic        ownerReq;
   logic [2:0]  otherReq;
   logic [1:0]  gapWin;
   logic [1:0]  handWin;

   // Round-robin search starting just after the last granted source.
   function automatic logic [1:0] rrPick(input logic [2:0] r, input logic [1:0] last);
      logic [1:0] pick;
      pick = last;
      case (last)
         2'd0: begin
            if (r[1])      pick = 2'd1;
            else if (r[2]) pick = 2'd2;
            else if (r[0]) pick = 2'd0;
         end
         2'd1: begin
            if (r[2])      pick = 2'd2;
            else if (r[0]) pick = 2'd0;
            else if (r[1]) pick = 2'd1;
         end
         default: begin
            if (r[0])      pick = 2'd0;
            else if (r[1]) pick = 2'd1;
            else if (r[2]) pick = 2'd2;
         end
      endcase
      return pick;
   endfunction

   function automatic logic [2:0] oneHot(input logic [1:0] idx);
      case (idx)
         2'd0:    return 3'b001;
         2'd1:    return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic reqBit(input logic [2:0] r, input logic [1:0] idx);
      case (idx)
         2'd0:    return r[0];
         2'd1:    return r[1];
         default: return r[2];
      endcase
   endfunction

   function automatic logic [3:0] patSel(input logic [1:0] idx, input logic [3:0] p0,
                                         input logic [3:0] p1, input logic [3:0] p2);
      case (idx)
         2'd0:    return p0;
         2'd1:    return p1;
         default: return p2;
      endcase
   endfunction

   // Winner candidates: the current owner's request, the others still waiting,
   // a re-pick when the chosen source gives up during the gap, and the next
   // owner on a handover (the current owner is masked out).
   assign ownerReq = reqBit(bus.req, win_q);
   assign otherReq = bus.req & ~oneHot(win_q);
   assign gapWin   = ownerReq ? win_q : rrPick(bus.req, last_q);
   assign handWin  = rrPick(otherReq, last_q);

   // Next-state and registered-output logic for the IDLE/GAP/GRANT controller.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      led_d   = led_q;
      oe_d    = oe_q;
      hold_d  = hold_q;
      gap_d   = gap_q;
      last_d  = last_q;
      win_d   = win_q;

      if (!bus.en) begin
         state_d = IDLE;
         gnt_d   = 3'b000;
         led_d   = 4'b0000;
         oe_d    = 1'b0;
         hold_d  = 32'd0;
         gap_d   = 8'd0;
      end else begin
         case (state_q)
            IDLE: begin
               gnt_d  = 3'b000;
               oe_d   = 1'b0;
               hold_d = 32'd0;
               gap_d  = 8'd0;
               if (|bus.req) begin
                  win_d   = rrPick(bus.req, last_q);
                  state_d = GAP;
               end
            end

            GAP: begin
               gnt_d = 3'b000;
               oe_d  = 1'b0;
               if (bus.req == 3'b000) begin
                  state_d = IDLE;
                  gap_d   = 8'd0;
               end else begin
                  win_d = gapWin;
                  if (gap_q >= GAP_CYCLES) begin
                     state_d = GRANT;
                     gnt_d   = oneHot(gapWin);
                     oe_d    = 1'b1;
                     led_d   = patSel(gapWin, bus.pat0, bus.pat1, bus.pat2);
                     hold_d  = 32'd0;
                     gap_d   = 8'd0;
                     last_d  = gapWin;
                  end else begin
                     gap_d = gap_q + 8'd1;
                  end
               end
            end

            GRANT: begin
               if (hold_q < MAX_HOLD) begin
                  hold_d = hold_q + 32'd1;
               end
               if (ownerReq) begin
                  led_d = patSel(win_q, bus.pat0, bus.pat1, bus.pat2);
               end
               if (hold_q >= MIN_HOLD - 32'd1) begin
                  if (!ownerReq && (otherReq != 3'b000)) begin
                     win_d  = handWin;
                     last_d = handWin;
                     gnt_d  = oneHot(handWin);
                     led_d  = patSel(handWin, bus.pat0, bus.pat1, bus.pat2);
                     oe_d   = 1'b1;
                     hold_d = 32'd0;
                  end else if (!ownerReq) begin
                     state_d = IDLE;
                     gnt_d   = 3'b000;
                     oe_d    = 1'b0;
                     led_d   = 4'b0000;
                     hold_d  = 32'd0;
                  end else if ((hold_q >= MAX_HOLD - 32'd1) && (otherReq != 3'b000)) begin
                     win_d  = handWin;
                     last_d = handWin;
                     gnt_d  = oneHot(handWin);
                     led_d  = patSel(handWin, bus.pat0, bus.pat1, bus.pat2);
                     oe_d   = 1'b1;
                     hold_d = 32'd0;
                  end
               end
            end

            default: begin
               state_d = IDLE;
               gnt_d   = 3'b000;
               led_d   = 4'b0000;
               oe_d    = 1'b0;
               hold_d  = 32'd0;
               gap_d   = 8'd0;
            end
         endcase
      end
   end

   // State and output registers; reset puts the pointer on source 2 so source 0 wins first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 3'b000;
         led_q   <= 4'b0000;
         oe_q    <= 1'b0;
         hold_q  <= 32'd0;
         gap_q   <= 8'd0;
         last_q  <= 2'd2;
         win_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         led_q   <= led_d;
         oe_q    <= oe_d;
         hold_q  <= hold_d;
         gap_q   <= gap_d;
         last_q  <= last_d;
         win_q   <= win_d;
      end
   end

   assign bus.gnt    = gnt_q;
   assign bus.led_o  = led_q;
   assign bus.led_oe = oe_q;
   assign bus.busy   = (state_q != IDLE);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Self-checking bench for led_bank_arbiter with MIN_HOLD=4, MAX_HOLD=8, GAP_CYCLES=2.
// A behavioural model tracks who owns the bank and for how long, and every
// sampled cycle is compared against it; directed steps add explicit checks
// for latency, min hold, timeslicing, handover and enable abort.
module tb_led_bank_arbiter;

   localparam logic [31:0] MIN_HOLD   = 32'd4;
   localparam logic [31:0] MAX_HOLD   = 32'd8;
   localparam logic [7:0]  GAP_CYCLES = 8'd2;
   localparam int MIN_I = 4;
   localparam int MAX_I = 8;
   localparam int GAP_I = 2;
   localparam int PH_IDLE = 0;
   localparam int PH_WAIT = 1;
   localparam int PH_OWN  = 2;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   // Model state: phase, current owner, last granted source, edges spent
   // waiting, cycles owned so far and the pattern on the pins.
   int         mPhase;
   int         mOwner;
   int         mLast;
   int         mWaited;
   int         mOwned;
   logic [3:0] mLed;
   int         heldCycles;

   led_bank_arbiter_if bus ();

   led_bank_arbiter #(
      .MIN_HOLD  (MIN_HOLD),
      .MAX_HOLD  (MAX_HOLD),
      .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Guard against a stuck run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] oneHot(input int idx);
      case (idx)
         0:       return 3'b001;
         1:       return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   function automatic logic hasReq(input logic [2:0] r, input int idx);
      case (idx)
         0:       return r[0];
         1:       return r[1];
         default: return r[2];
      endcase
   endfunction

   // First requesting source after 'last' in circular order 0,1,2.
   function automatic int nextAfter(input int last, input logic [2:0] mask);
      for (int k = 1; k <= 3; k++) begin
         int c;
         c = (last + k) % 3;
         if (hasReq(mask, c)) return c;
      end
      return last;
   endfunction

   function automatic logic [3:0] patOf(input int idx);
      case (idx)
         0:       return bus.pat0;
         1:       return bus.pat1;
         default: return bus.pat2;
      endcase
   endfunction

   task automatic modelReset();
      mPhase  = PH_IDLE;
      mOwner  = 0;
      mLast   = 2;
      mWaited = 0;
      mOwned  = 0;
      mLed    = 4'h0;
   endtask

   task automatic handOver(input logic [2:0] others);
      mOwner = nextAfter(mLast, others);
      mLast  = mOwner;
      mOwned = 1;
      mLed   = patOf(mOwner);
   endtask

   // One clock edge of the bank's ownership rules, using the inputs as sampled.
   task automatic modelEdge();
      logic [2:0] r;
      logic [2:0] others;
      r = bus.req;
      if (!bus.en) begin
         mPhase = PH_IDLE;
         mLed   = 4'h0;
      end else if (mPhase == PH_IDLE) begin
         if (r != 3'b000) begin
            mOwner  = nextAfter(mLast, r);
            mWaited = 0;
            mPhase  = PH_WAIT;
         end
      end else if (mPhase == PH_WAIT) begin
         if (r == 3'b000) begin
            mPhase = PH_IDLE;
         end else begin
            if (!hasReq(r, mOwner)) mOwner = nextAfter(mLast, r);
            if (mWaited == GAP_I) begin
               mPhase = PH_OWN;
               mLast  = mOwner;
               mOwned = 1;
               mLed   = patOf(mOwner);
            end else begin
               mWaited++;
            end
         end
      end else begin
         others = r & ~oneHot(mOwner);
         if (hasReq(r, mOwner)) mLed = patOf(mOwner);
         if (mOwned < MIN_I) begin
            mOwned++;
         end else if (!hasReq(r, mOwner) && others != 3'b000) begin
            handOver(others);
         end else if (!hasReq(r, mOwner)) begin
            mPhase = PH_IDLE;
            mLed   = 4'h0;
         end else if (mOwned >= MAX_I && others != 3'b000) begin
            handOver(others);
         end else begin
            mOwned++;
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [2:0] expGnt;
      expGnt = (mPhase == PH_OWN) ? oneHot(mOwner) : 3'b000;
      chk({tag, ".gnt"},    32'(bus.gnt),    32'(expGnt));
      chk({tag, ".led_oe"}, 32'(bus.led_oe), 32'(mPhase == PH_OWN));
      chk({tag, ".led_o"},  32'(bus.led_o),  32'(mLed));
      chk({tag, ".busy"},   32'(bus.busy),   32'(mPhase != PH_IDLE));
   endtask

   task automatic applyStimulus(input logic e, input logic [2:0] r);
      bus.en  = e;
      bus.req = r;
   endtask

   // Advance one clock: model follows the edge, outputs checked on the falling edge.
   task automatic runCycle(input string tag);
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      checkOutput(tag);
   endtask

   initial begin
      rst_n    = 1'b0;
      bus.en   = 1'b0;
      bus.req  = 3'b000;
      bus.pat0 = 4'h0;
      bus.pat1 = 4'h0;
      bus.pat2 = 4'h0;
      modelReset();
      @(negedge clk);
      checkOutput("reset");

      // Latency from IDLE: req sampled at edge k gives a grant after edge k+3.
      bus.pat0 = 4'h5;
      applyStimulus(1'b1, 3'b001);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         runCycle("lat");
         chk("lat_gnt_low", 32'(bus.gnt), 32'd0);
      end
      runCycle("lat");
      chk("lat_gnt", 32'(bus.gnt), 32'h1);
      chk("lat_oe",  32'(bus.led_oe), 32'd1);
      chk("lat_led", 32'(bus.led_o), 32'h5);
      runCycle("lat");
      runCycle("lat");

      // Asynchronous reset in the middle of a grant.
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      chk("arst_gnt", 32'(bus.gnt), 32'd0);
      chk("arst_oe",  32'(bus.led_oe), 32'd0);
      chk("arst_led", 32'(bus.led_o), 32'd0);
      chk("arst_busy", 32'(bus.busy), 32'd0);
      @(negedge clk);
      checkOutput("arst_hold");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         runCycle("relat");
         chk("relat_gnt_low", 32'(bus.gnt), 32'd0);
      end
      runCycle("relat");
      chk("relat_gnt", 32'(bus.gnt), 32'h1);

      // Single source tracking a changing pattern, then releasing.
      applyStimulus(1'b1, 3'b000);
      for (int i = 0; i < 6; i++) runCycle("idle1");
      bus.pat1 = 4'b1100;
      applyStimulus(1'b1, 3'b010);
      for (int i = 0; i < 4; i++) runCycle("single");
      chk("single_led_c", 32'(bus.led_o), 32'hC);
      bus.pat1 = 4'b1001;
      runCycle("single");
      chk("single_led_9", 32'(bus.led_o), 32'h9);
      for (int i = 0; i < 4; i++) runCycle("single");
      applyStimulus(1'b1, 3'b000);
      runCycle("single_drop");
      chk("single_drop_oe", 32'(bus.led_oe), 32'd0);
      chk("single_drop_gnt", 32'(bus.gnt), 32'd0);

      // Minimum hold: owner releases after one granted cycle, grant lasts 4 cycles.
      bus.pat0 = 4'h3;
      applyStimulus(1'b1, 3'b001);
      for (int i = 0; i < 4; i++) runCycle("minhold");
      chk("minhold_led", 32'(bus.led_o), 32'h3);
      heldCycles = (bus.gnt == 3'b001) ? 1 : 0;
      applyStimulus(1'b1, 3'b000);
      bus.pat0 = 4'hE;
      for (int i = 0; i < 8; i++) begin
         runCycle("minhold");
         if (bus.gnt == 3'b001) begin
            heldCycles++;
            chk("minhold_frozen", 32'(bus.led_o), 32'h3);
         end
      end
      chk("minhold_cycles", 32'(heldCycles), 32'd4);
      chk("minhold_end_oe", 32'(bus.led_oe), 32'd0);

      // Timeslice fairness from reset: order 0,1,2,0 with 8 cycles each, no gaps.
      rst_n = 1'b0;
      #1;
      modelReset();
      @(negedge clk);
      bus.pat0 = 4'h1;
      bus.pat1 = 4'h2;
      bus.pat2 = 4'h4;
      applyStimulus(1'b1, 3'b111);
      rst_n = 1'b1;
      for (int i = 0; i < 36; i++) begin
         runCycle("slice");
         if (i < 3) begin
            chk("slice_gap", 32'(bus.gnt), 32'd0);
         end else begin
            chk("slice_owner", 32'(bus.gnt), 32'(oneHot(((i - 3) / 8) % 3)));
            chk("slice_oe", 32'(bus.led_oe), 32'd1);
         end
      end

      // Voluntary handover: owner 0 drops while 2 waits, 2 takes over with no gap.
      applyStimulus(1'b1, 3'b000);
      for (int i = 0; i < 10; i++) runCycle("idle2");
      bus.pat0 = 4'h6;
      bus.pat2 = 4'hA;
      applyStimulus(1'b1, 3'b001);
      for (int i = 0; i < 4; i++) runCycle("vol");
      applyStimulus(1'b1, 3'b101);
      for (int i = 0; i < 4; i++) runCycle("vol");
      chk("vol_before", 32'(bus.gnt), 32'h1);
      applyStimulus(1'b1, 3'b100);
      runCycle("vol");
      chk("vol_gnt", 32'(bus.gnt), 32'h4);
      chk("vol_led", 32'(bus.led_o), 32'hA);
      chk("vol_oe",  32'(bus.led_oe), 32'd1);

      // Enable abort during the gap and during a grant, then a fresh gap.
      applyStimulus(1'b1, 3'b000);
      for (int i = 0; i < 10; i++) runCycle("idle3");
      applyStimulus(1'b1, 3'b010);
      runCycle("abort");
      chk("abort_gap_busy", 32'(bus.busy), 32'd1);
      applyStimulus(1'b0, 3'b010);
      runCycle("abort");
      chk("abort_gap_idle", 32'(bus.busy), 32'd0);
      applyStimulus(1'b1, 3'b010);
      for (int i = 0; i < 4; i++) runCycle("abort");
      chk("abort_grant", 32'(bus.gnt), 32'h2);
      applyStimulus(1'b0, 3'b010);
      runCycle("abort");
      chk("abort_oe", 32'(bus.led_oe), 32'd0);
      chk("abort_led", 32'(bus.led_o), 32'd0);
      applyStimulus(1'b1, 3'b010);
      for (int i = 0; i < 3; i++) begin
         runCycle("regap");
         chk("regap_low", 32'(bus.led_oe), 32'd0);
      end
      runCycle("regap");
      chk("regap_gnt", 32'(bus.gnt), 32'h2);

      // Random requests, patterns and occasional enable drops against the model.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 3) == 0) bus.req = 3'($urandom);
         bus.en   = ($urandom_range(0, 19) != 0);
         bus.pat0 = 4'($urandom);
         bus.pat1 = 4'($urandom);
         bus.pat2 = 4'($urandom);
         runCycle("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
